// File: rtl/det_elim_scheduler.sv
// Gaussian-elimination op sequencer for the 32x32 matrix RAM.
// Issues (k,i,j) update ops and pivot events with a per-pivot barrier.
module det_elim_scheduler #(
  parameter int MAX_OUTSTANDING = 8,
  parameter int CNT_W           = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [5:0] mxsize,
  output logic       busy,
  output logic       done,
  output logic       op_valid,
  input  logic       op_ready,
  output logic [4:0] op_k,
  output logic [4:0] op_row,
  output logic [4:0] op_col,
  output logic [9:0] op_addr,
  output logic       op_last,
  input  logic       wb_done,
  output logic       piv_valid,
  output logic [4:0] piv_k,
  output logic [9:0] piv_addr,
  output logic       err_underflow
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_FINISH
  } state_t;

  state_t           r_state;
  state_t           w_nxt;
  logic [5:0]       r_n;
  logic [4:0]       r_k;
  logic [4:0]       r_i;
  logic [4:0]       r_j;
  logic             r_first;
  logic [CNT_W-1:0] r_out;
  logic             r_err;

  logic [5:0] w_n_cap;
  logic [5:0] w_nm1;
  logic       w_acc;
  logic       w_room;
  logic       w_j_at_k;
  logic       w_last_row;
  logic       w_k_end;
  logic       w_drain_ok;

  assign w_n_cap    = (mxsize > 6'd32) ? 6'd32 : mxsize;
  assign w_nm1      = r_n - 6'd1;
  assign w_room     = r_out < CNT_W'(MAX_OUTSTANDING);
  assign w_acc      = op_valid && op_ready;
  assign w_j_at_k   = (r_j == r_k);
  assign w_last_row = ({1'b0, r_i} == w_nm1);
  assign w_k_end    = ({1'b0, r_k} == (r_n - 6'd2));
  assign w_drain_ok = (r_out == '0) && !wb_done;

  assign op_k          = r_k;
  assign op_row        = r_i;
  assign op_col        = r_j;
  assign op_addr       = {r_i, r_j};
  assign op_last       = w_j_at_k;
  assign piv_addr      = {piv_k, piv_k};
  assign err_underflow = r_err;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (start)
          w_nxt = (w_n_cap < 6'd2) ? S_FINISH : S_ISSUE;
      end
      S_ISSUE: begin
        if (w_acc && w_j_at_k && w_last_row)
          w_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (w_drain_ok)
          w_nxt = w_k_end ? S_FINISH : S_ISSUE;
      end
      S_FINISH: w_nxt = S_IDLE;
      default:  w_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    op_valid  = 1'b0;
    piv_valid = 1'b0;
    piv_k     = r_k;
    unique case (r_state)
      S_ISSUE: begin
        busy      = 1'b1;
        op_valid  = w_room;
        piv_valid = r_first;
      end
      S_DRAIN: busy = 1'b1;
      S_FINISH: begin
        done      = 1'b1;
        piv_valid = (r_n != 6'd0);
        piv_k     = w_nm1[4:0];
      end
      default: ;
    endcase
  end

  // Columns walk right-to-left so A[i][k] is the last element rewritten.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_n     <= '0;
      r_k     <= '0;
      r_i     <= '0;
      r_j     <= '0;
      r_first <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_n     <= w_n_cap;
            r_k     <= '0;
            r_i     <= 5'd1;
            r_j     <= w_n_cap[4:0] - 5'd1;
            r_first <= 1'b1;
          end
        end
        S_ISSUE: begin
          r_first <= 1'b0;
          if (w_acc) begin
            if (!w_j_at_k) begin
              r_j <= r_j - 5'd1;
            end else if (!w_last_row) begin
              r_i <= r_i + 5'd1;
              r_j <= w_nm1[4:0];
            end
          end
        end
        S_DRAIN: begin
          if (w_drain_ok && !w_k_end) begin
            r_k     <= r_k + 5'd1;
            r_i     <= r_k + 5'd2;
            r_j     <= w_nm1[4:0];
            r_first <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out <= '0;
      r_err <= 1'b0;
    end else begin
      unique case ({w_acc, wb_done})
        2'b10: r_out <= r_out + 1'b1;
        2'b01: begin
          if (r_out == '0) r_err <= 1'b1;
          else             r_out <= r_out - 1'b1;
        end
        2'b11: begin
          if (r_out == '0) r_err <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_det_elim_scheduler.sv
// Scoreboard bench for det_elim_scheduler.
// Expected ops/pivots are queued at start and popped on DUT output.
module tb_det_elim_scheduler;

  localparam int MAXO = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [5:0] mxsize = '0;
  logic       busy;
  logic       done;
  logic       op_valid;
  logic       op_ready = 1'b1;
  logic [4:0] op_k;
  logic [4:0] op_row;
  logic [4:0] op_col;
  logic [9:0] op_addr;
  logic       op_last;
  logic       wb_done = 1'b0;
  logic       piv_valid;
  logic [4:0] piv_k;
  logic [9:0] piv_addr;
  logic       err_underflow;

  det_elim_scheduler #(
    .MAX_OUTSTANDING(MAXO),
    .CNT_W(4)
  ) u_dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .mxsize(mxsize),
    .busy(busy),
    .done(done),
    .op_valid(op_valid),
    .op_ready(op_ready),
    .op_k(op_k),
    .op_row(op_row),
    .op_col(op_col),
    .op_addr(op_addr),
    .op_last(op_last),
    .wb_done(wb_done),
    .piv_valid(piv_valid),
    .piv_k(piv_k),
    .piv_addr(piv_addr),
    .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [31:0] opq[$];
  logic [4:0]  pq[$];

  logic       rdy_en = 1'b1;
  logic       auto_wb = 1'b1;
  logic       wb_man = 1'b0;
  logic [2:0] sh = '0;
  int         stall_left = 0;
  int         stall_after = 0;
  int         acc_run = 0;
  int         ret_cnt = 0;
  int         last_k = -1;
  int         exp_total = 0;
  bit         seen_done = 1'b0;

  always @(negedge clk) begin
    logic        acc;
    logic [31:0] g;
    logic [31:0] e;
    logic [4:0]  pk;
    if (stall_left > 0 && acc_run == stall_after) begin
      op_ready = 1'b0;
      stall_left--;
    end else begin
      op_ready = rdy_en;
    end
    acc = op_valid && op_ready && !reset;
    g = {6'd0, op_k, op_row, op_col, op_last, op_addr};
    if (op_valid && !reset) begin
      if (opq.size() == 0) begin
        check("op_extra", 32'(opq.size()), 32'd1);
      end else if (acc) begin
        e = opq.pop_front();
        check("op", g, e);
        if (int'(op_k) != last_k) begin
          check("barrier", 32'(ret_cnt), 32'(acc_run));
          last_k = int'(op_k);
        end
        acc_run++;
      end else begin
        check("stall", g, opq[0]);
      end
    end
    if (piv_valid && !reset) begin
      if (pq.size() == 0) begin
        check("piv_extra", 32'(pq.size()), 32'd1);
      end else begin
        pk = pq.pop_front();
        check("piv_k", 32'(piv_k), 32'(pk));
        check("piv_addr", 32'(piv_addr), 32'({pk, pk}));
      end
    end
    if (done && !reset) begin
      seen_done = 1'b1;
      check("done_ops_left", 32'(opq.size()), 32'd0);
      check("done_piv_left", 32'(pq.size()), 32'd0);
    end
    sh = {sh[1:0], acc && auto_wb};
    if (reset) sh = '0;
    wb_done = sh[2] | wb_man;
    if (wb_done) ret_cnt++;
  end

  task automatic start_run(input logic [5:0] n);
    int ne;
    ne = (n > 6'd32) ? 32 : int'(n);
    for (int k = 0; k <= ne - 2; k++)
      for (int i = k + 1; i < ne; i++)
        for (int j = ne - 1; j >= k; j--)
          opq.push_back({6'd0, 5'(k), 5'(i), 5'(j), (j == k),
                         5'(i), 5'(j)});
    for (int k = 0; k <= ne - 2; k++) pq.push_back(5'(k));
    if (ne >= 1) pq.push_back(5'(ne - 1));
    exp_total = (ne * ne * ne - ne) / 3;
    acc_run   = 0;
    ret_cnt   = 0;
    last_k    = -1;
    seen_done = 1'b0;
    @(posedge clk);
    #1 start = 1'b1;
    mxsize = n;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    #1;
    if (ne >= 2) begin
      check("lat_op", 32'(op_valid), 32'd1);
      check("lat_busy", 32'(busy), 32'd1);
    end else begin
      check("lat_done", 32'(done), 32'd1);
      check("lat_busy0", 32'(busy), 32'd0);
    end
  endtask

  task automatic wait_done(input int lim);
    for (int c = 0; c < lim && !seen_done; c++) @(posedge clk);
    check("timeout", 32'(seen_done), 32'd1);
    check("ops_total", 32'(acc_run), 32'(exp_total));
    @(negedge clk);
    #1 check("busy_end", 32'(busy), 32'd0);
  endtask

  task automatic pulse_wb(input int len);
    @(posedge clk);
    #1 wb_man = 1'b1;
    repeat (len) @(posedge clk);
    #1 wb_man = 1'b0;
  endtask

  task automatic settle(input int cyc);
    repeat (cyc) @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  initial begin
    settle(3);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_piv", 32'(piv_valid), 32'd0);
    check("rst_opv", 32'(op_valid), 32'd0);
    check("rst_err", 32'(err_underflow), 32'd0);
    reset = 1'b0;

    start_run(6'd3);
    wait_done(500);
    start_run(6'd1);
    wait_done(50);
    start_run(6'd0);
    wait_done(50);

    stall_after = 5;
    stall_left  = 5;
    start_run(6'd4);
    wait_done(1000);

    auto_wb = 1'b0;
    start_run(6'd4);
    settle(6);
    check("max_acc", 32'(acc_run), 32'd2);
    check("max_vld", 32'(op_valid), 32'd0);
    pulse_wb(1);
    settle(6);
    check("one_wb_acc", 32'(acc_run), 32'd3);
    check("one_wb_vld", 32'(op_valid), 32'd0);
    pulse_wb(2);
    settle(6);
    check("simul_acc", 32'(acc_run), 32'd5);
    check("simul_vld", 32'(op_valid), 32'd0);
    auto_wb = 1'b1;
    pulse_wb(2);
    wait_done(1000);

    check("err_pre", 32'(err_underflow), 32'd0);
    pulse_wb(1);
    settle(1);
    check("err_set", 32'(err_underflow), 32'd1);
    start_run(6'd3);
    wait_done(500);
    check("err_sticky", 32'(err_underflow), 32'd1);

    start_run(6'd8);
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    opq.delete();
    pq.delete();
    @(negedge clk);
    #1;
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_opv", 32'(op_valid), 32'd0);
    check("mid_done", 32'(done), 32'd0);
    check("mid_err", 32'(err_underflow), 32'd0);
    settle(4);
    check("mid_nodone", 32'(seen_done), 32'd0);
    check("mid_idle_piv", 32'(piv_valid), 32'd0);

    start_run(6'd8);
    wait_done(3000);
    start_run(6'd40);
    wait_done(60000);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
